// File: rtl/s_axi_pkg.sv
// rtl/s_axi_pkg.sv - AXI response/burst codes and transaction error check for s_axi
package s_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // WRAP and reserved bursts still run as INCR; they only raise the error flag
  function automatic logic burst_err(input logic [2:0] size, input logic [2:0] size_exp,
                                     input logic [1:0] burst);
    return (size != size_exp) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
  endfunction

endpackage

// File: rtl/s_axi_ram.sv
// rtl/s_axi_ram.sv - byte-enabled single-write, registered-read RAM behind s_axi
module s_axi_ram #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                i_we,
  input  logic [DWIDTH/8-1:0] i_wstrb,
  input  logic [AWIDTH-1:0]   i_waddr,
  input  logic [DWIDTH-1:0]   i_wdata,
  input  logic                i_re,
  input  logic [AWIDTH-1:0]   i_raddr,
  output logic [DWIDTH-1:0]   o_rdata
);

  logic [DWIDTH-1:0] r_mem [0:(1<<AWIDTH)-1];
  logic [DWIDTH-1:0] r_rdata;

  // Contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DWIDTH/8; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Same-cycle read of a word being written returns the old contents
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/s_axi.sv
// rtl/s_axi.sv - AXI4 slave with independent write/read FSMs over a shared internal RAM
module s_axi
  import s_axi_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int ID_WIDTH     = 1,
  parameter int MEM_WIDTH    = 32,
  parameter int MEM_AWIDTH   = 10,
  parameter int BUSER_WIDTH  = 1,
  parameter int RUSER_WIDTH  = 1,
  parameter int AWUSER_WIDTH = 1,
  parameter int WUSER_WIDTH  = 1,
  parameter int ARUSER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    xrst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [MEM_WIDTH-1:0]    awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic [3:0]              awqos,
  input  logic [AWUSER_WIDTH-1:0] awuser,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DWIDTH-1:0]       wdata,
  input  logic [DWIDTH/8-1:0]     wstrb,
  input  logic                    wlast,
  input  logic [WUSER_WIDTH-1:0]  wuser,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic [BUSER_WIDTH-1:0]  buser,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [MEM_WIDTH-1:0]    araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic [3:0]              arqos,
  input  logic [ARUSER_WIDTH-1:0] aruser,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DWIDTH-1:0]       rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic [RUSER_WIDTH-1:0]  ruser
);

  localparam int S = $clog2(DWIDTH/8);
  localparam logic [2:0] SIZE_EXP = 3'(S);
  localparam logic [MEM_AWIDTH-1:0] IDX_ONE = MEM_AWIDTH'(1);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0]            r_wstate;
  logic [ID_WIDTH-1:0]   r_wid;
  logic [MEM_AWIDTH-1:0] r_widx;
  logic [7:0]            r_wlen, r_wcnt;
  logic                  r_wfix, r_werr;

  logic [0:0]            r_rstate;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [MEM_AWIDTH-1:0] r_ridx;
  logic [7:0]            r_rlen, r_rcnt;
  logic                  r_rfix, r_rerr;

  logic                  w_we, w_wcnt_end, w_wend;
  logic [MEM_AWIDTH-1:0] w_widx_next, w_aw_idx, w_ar_idx, w_ridx_next, w_raddr;
  logic                  w_ren, w_rcnt_end;
  logic [DWIDTH-1:0]     w_rdata;
  logic                  w_unused;

  assign w_aw_idx    = awaddr[MEM_AWIDTH+S-1:S];
  assign w_ar_idx    = araddr[MEM_AWIDTH+S-1:S];
  assign w_we        = (r_wstate == W_DATA) && wvalid;
  assign w_wcnt_end  = (r_wcnt == r_wlen);
  assign w_wend      = wlast || w_wcnt_end;
  assign w_widx_next = r_wfix ? r_widx : r_widx + IDX_ONE;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wfix   <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (awvalid) begin
          r_wid    <= awid;
          r_widx   <= w_aw_idx;
          r_wlen   <= awlen;
          r_wcnt   <= '0;
          r_wfix   <= (awburst == BURST_FIXED);
          r_werr   <= burst_err(awsize, SIZE_EXP, awburst);
          r_wstate <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          r_widx <= w_widx_next;
          r_wcnt <= r_wcnt + 8'd1;
          // A burst ends on whichever comes first; disagreement is a protocol error
          if (w_wend) begin
            if (wlast != w_wcnt_end) r_werr <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign w_rcnt_end  = (r_rcnt == r_rlen);
  assign w_ridx_next = r_rfix ? r_ridx : r_ridx + IDX_ONE;
  // Prefetch the next beat on every accepted non-last beat to sustain one beat per cycle
  assign w_ren   = ((r_rstate == R_IDLE) && arvalid) ||
                   ((r_rstate == R_DATA) && rready && !w_rcnt_end);
  assign w_raddr = (r_rstate == R_IDLE) ? w_ar_idx : w_ridx_next;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rfix   <= 1'b0;
      r_rerr   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: if (arvalid) begin
          r_rid    <= arid;
          r_ridx   <= w_ar_idx;
          r_rlen   <= arlen;
          r_rcnt   <= '0;
          r_rfix   <= (arburst == BURST_FIXED);
          r_rerr   <= burst_err(arsize, SIZE_EXP, arburst);
          r_rstate <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (w_rcnt_end) begin
            r_rstate <= R_IDLE;
          end else begin
            r_ridx <= w_ridx_next;
            r_rcnt <= r_rcnt + 8'd1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  s_axi_ram #(.DWIDTH(DWIDTH), .AWIDTH(MEM_AWIDTH)) u_ram (
    .clk     (clk),
    .xrst    (xrst),
    .i_we    (w_we),
    .i_wstrb (wstrb),
    .i_waddr (r_widx),
    .i_wdata (wdata),
    .i_re    (w_ren),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign awready = (r_wstate == W_IDLE);
  assign wready  = (r_wstate == W_DATA);
  assign bvalid  = (r_wstate == W_RESP);
  assign bid     = r_wid;
  assign bresp   = (bvalid && r_werr) ? RESP_SLVERR : RESP_OKAY;
  assign buser   = '0;
  assign arready = (r_rstate == R_IDLE);
  assign rvalid  = (r_rstate == R_DATA);
  assign rid     = r_rid;
  assign rdata   = w_rdata;
  assign rlast   = rvalid && w_rcnt_end;
  assign rresp   = (rvalid && r_rerr) ? RESP_SLVERR : RESP_OKAY;
  assign ruser   = '0;

  assign w_unused = ^{awlock, awcache, awprot, awqos, awuser, wuser, awaddr,
                      arlock, arcache, arprot, arqos, aruser, araddr};

endmodule

// File: tb/tb_s_axi.sv
// tb/tb_s_axi.sv - scoreboard testbench for s_axi
module tb_s_axi;

  typedef struct { logic id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic id; } rexp_t;

  logic clk = 1'b0;
  logic xrst;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready;
  logic rvalid, rready, rlast;
  logic [0:0] awid, bid, arid, rid, awuser, wuser, aruser, buser, ruser;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb, awcache, awqos, arcache, arqos;
  logic awlock, arlock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ar_cyc = 0;
  int last_r_cyc = 0;
  bexp_t exp_b[$];
  rexp_t exp_r[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s_axi dut (
    .clk(clk), .xrst(xrst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awqos(awqos), .awuser(awuser),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wuser(wuser),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arqos(arqos), .aruser(aruser),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .ruser(ruser)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic id, input logic [1:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last,
                        input logic id);
    rexp_t e;
    e.data = data; e.resp = resp; e.last = last; e.id = id;
    exp_r.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever a B or R handshake is about to happen
  always @(negedge clk) begin
    bexp_t eb;
    rexp_t er;
    if (xrst) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          check("bid", bid, eb.id);
          check("bresp", bresp, eb.resp);
          check("buser", buser, 0);
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else begin
          er = exp_r.pop_front();
          check("rdata", rdata, er.data);
          check("rresp", rresp, er.resp);
          check("rlast", rlast, er.last);
          check("rid", rid, er.id);
          if (rlast) last_r_cyc = cyc;
        end
      end
    end
  end

  task automatic aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    @(posedge clk); #1;
    wvalid = 1; wdata = data; wstrb = strb; wlast = last;
    @(negedge clk);
    while (!wready && n < 100) begin @(negedge clk); n++; end
    check("w_accept", wready, 1);
    @(posedge clk); #1;
    wvalid = 0; wlast = 0;
  endtask

  task automatic ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("ar_accept", arready, 1);
    @(posedge clk); #1;
    ar_cyc = cyc;
    arvalid = 0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("b_drain", exp_b.size(), 0);
    exp_b.delete();
  endtask

  task automatic wait_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("r_drain", exp_r.size(), 0);
    exp_r.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        hold_chk;
    xrst = 0; bready = 1; rready = 1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    awlock = 0; awcache = 0; awprot = 0; awqos = 0; awuser = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wuser = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    arlock = 0; arcache = 0; arprot = 0; arqos = 0; aruser = 0;

    repeat (3) @(negedge clk);
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rlast", rlast, 0);
    #2 xrst = 1;

    // 16-beat INCR write of 0..15 then read back at one beat per cycle
    push_b(1, 2'b00);
    aw(1, 32'h0, 8'd15, 3'd2, 2'b01);
    for (int i = 0; i < 16; i++) wbeat(i, 4'hF, i == 15);
    check("bvalid_after_last_w", bvalid, 1);
    wait_b();
    for (int i = 0; i < 16; i++) push_r(i, 2'b00, i == 15, 1);
    ar(1, 32'h0, 8'd15, 3'd2, 2'b01);
    wait_r();
    check("r_burst_cycles", last_r_cyc - ar_cyc, 15);

    // Byte strobes on a FIXED burst
    push_b(0, 2'b00);
    aw(0, 32'h40, 8'd0, 3'd2, 2'b01);
    wbeat(32'hAABBCCDD, 4'hF, 1);
    wait_b();
    push_b(0, 2'b00);
    aw(0, 32'h40, 8'd1, 3'd2, 2'b00);
    wbeat(32'h11111111, 4'b0001, 0);
    wbeat(32'h22222222, 4'b1000, 1);
    wait_b();
    push_r(32'h22BBCC11, 2'b00, 1, 0);
    ar(0, 32'h40, 8'd0, 3'd2, 2'b01);
    wait_r();

    // rready toggling during an 8-beat read
    for (int i = 0; i < 8; i++) push_r(i, 2'b00, i == 7, 0);
    ar(0, 32'h0, 8'd7, 3'd2, 2'b01);
    for (int i = 0; i < 40 && exp_r.size() != 0; i++) begin
      rready = (i % 2 == 0);
      hold_chk = 0;
      @(negedge clk);
      if (!rready && rvalid) begin held = rdata; hold_chk = 1; end
      @(posedge clk); #1;
      if (hold_chk) begin
        check("rdata_hold", rdata, held);
        check("rvalid_hold", rvalid, 1);
      end
    end
    rready = 1;
    wait_r();

    // bready held low keeps the response pending and blocks new AW
    bready = 0;
    push_b(0, 2'b00);
    aw(0, 32'h80, 8'd0, 3'd2, 2'b01);
    wbeat(32'h12345678, 4'hF, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_held", bvalid, 1);
      check("awready_blocked", awready, 0);
    end
    bready = 1;
    wait_b();

    // Wrong size: SLVERR but data still written
    push_b(1, 2'b10);
    aw(1, 32'h100, 8'd0, 3'd1, 2'b01);
    wbeat(32'hCAFEF00D, 4'hF, 1);
    wait_b();
    push_r(32'hCAFEF00D, 2'b00, 1, 1);
    ar(1, 32'h100, 8'd0, 3'd2, 2'b01);
    wait_r();

    // WRAP read runs as INCR with SLVERR on every beat
    for (int i = 0; i < 4; i++) push_r(i, 2'b10, i == 3, 0);
    ar(0, 32'h0, 8'd3, 3'd2, 2'b10);
    wait_r();

    // Early wlast on an awlen=3 burst, then a normal write is accepted
    push_b(0, 2'b10);
    aw(0, 32'h200, 8'd3, 3'd2, 2'b01);
    wbeat(32'h000000A0, 4'hF, 0);
    wbeat(32'h000000A1, 4'hF, 1);
    wait_b();
    push_b(1, 2'b00);
    aw(1, 32'h200, 8'd0, 3'd2, 2'b01);
    wbeat(32'h00000055, 4'hF, 1);
    wait_b();
    push_r(32'h00000055, 2'b00, 0, 0);
    push_r(32'h000000A1, 2'b00, 1, 0);
    ar(0, 32'h200, 8'd1, 3'd2, 2'b01);
    wait_r();

    // Same-cycle write and read of word 5: read sees the old value
    push_b(0, 2'b00);
    push_r(32'd5, 2'b00, 1, 0);
    aw(0, 32'h14, 8'd0, 3'd2, 2'b01);
    wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1;
    arvalid = 1; arid = 0; araddr = 32'h14; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; arvalid = 0;
    wait_b();
    wait_r();
    push_r(32'hDEADBEEF, 2'b00, 1, 1);
    ar(1, 32'h14, 8'd0, 3'd2, 2'b01);
    wait_r();

    // Reset mid-read drops the burst asynchronously; RAM keeps its contents
    rready = 0;
    ar(0, 32'h0, 8'd15, 3'd2, 2'b01);
    @(negedge clk);
    check("rvalid_before_reset", rvalid, 1);
    #2 xrst = 0;
    #1;
    check("async_rst_rvalid", rvalid, 0);
    check("async_rst_rlast", rlast, 0);
    check("async_rst_rdata", rdata, 0);
    check("async_rst_arready", arready, 1);
    @(negedge clk);
    #2 xrst = 1;
    rready = 1;
    push_r(32'd1, 2'b00, 1, 0);
    ar(0, 32'h4, 8'd0, 3'd2, 2'b01);
    wait_r();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
